seq_multiplier: RTL and testbench

//   Parametrised iterative shift-add multiplier; sequential successor to the

---
 rtl/mult_pkg.sv | 27 ++
 rtl/mult_step.sv | 24 ++
 rtl/seq_multiplier.sv | 122 ++++++++++++
 tb/tb_seq_multiplier.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// ----------------------------------------------------------------------------
// mult_pkg
//   Shared types and helpers for the iterative shift-add multiplier.
//   - state_t   : controller states (IDLE, RUN, DONE)
//   - MAX_WIDTH : width of the operand container used by abs_val
//   - abs_val   : magnitude of a sign-extended two's-complement value
// ----------------------------------------------------------------------------
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operands are sign- or zero-extended into this container before taking
    // the magnitude. Supported operand widths are therefore 2..MAX_WIDTH-1.
    localparam int MAX_WIDTH = 64;

    // The caller extends the operand into MAX_WIDTH bits, so the top bit is
    // the sign bit only for signed operands. The most negative operand value
    // -2^(W-1) yields 2^(W-1), which still fits in W unsigned bits.
    function automatic logic [MAX_WIDTH-1:0] abs_val(input logic [MAX_WIDTH-1:0] value);
        return value[MAX_WIDTH-1] ? -value : value;
    endfunction

endpackage

// File: rtl/mult_step.sv
// ----------------------------------------------------------------------------
// mult_step
//   One row of the shift-add multiplier: conditionally adds the multiplicand
//   into the upper half of the accumulator. This is the per-bit AND+add of a
//   single array cell widened to a full WIDTH-bit row.
// Ports
//   acc_upper   in   WIDTH     upper half of the running accumulator
//   mcand       in   WIDTH     multiplicand magnitude
//   mplier_bit  in   1         current multiplier bit (LSB of shifted multiplier)
//   sum         out  WIDTH+1   acc_upper + (mplier_bit ? mcand : 0), with carry
// ----------------------------------------------------------------------------
module mult_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc_upper,
    input  logic [WIDTH-1:0] mcand,
    input  logic             mplier_bit,
    output logic [WIDTH:0]   sum
);

    assign sum = mplier_bit ? ({1'b0, acc_upper} + {1'b0, mcand})
                            : {1'b0, acc_upper};

endmodule

// File: rtl/seq_multiplier.sv
// ----------------------------------------------------------------------------
// seq_multiplier
//   Iterative shift-add multiplier, one multiplier bit per clock. Operates on
//   magnitudes and negates the final product when the operand signs differ,
//   so signed and unsigned operations share the same datapath. Fixed latency:
//   a start accepted at edge E gives done=1 and the new product after edge
//   E+WIDTH.
// Parameters
//   WIDTH      operand width (2..63); product is 2*WIDTH bits
//   SIGNED_EN  1: signedMode honoured; 0: always unsigned
// Ports
//   clock         in   1          rising-edge clock
//   reset         in   1          synchronous, active-high
//   start         in   1          request; accepted only while ready=1
//   signedMode    in   1          operands are two's complement (sampled with start)
//   multiplicand  in   WIDTH      sampled on an accepted start
//   multiplier    in   WIDTH      sampled on an accepted start
//   ready         out  1          high in IDLE and DONE
//   done          out  1          one-cycle pulse when product updates
//   product       out  2*WIDTH    last result, held until the next completion
// ----------------------------------------------------------------------------
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SIGNED_EN = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signedMode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 ready,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t               state;
    logic [CW-1:0]        counter;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic                 neg_flag;

    logic                 signed_op;
    logic [MAX_WIDTH-1:0] mcand_ext;
    logic [MAX_WIDTH-1:0] mplier_ext;
    logic [WIDTH-1:0]     mcand_mag;
    logic [WIDTH-1:0]     mplier_mag;
    logic                 neg_in;
    logic [WIDTH:0]       row_sum;
    logic [2*WIDTH-1:0]   acc_next;

    assign signed_op = signedMode & (SIGNED_EN != 0);

    // Sign-extend only in signed mode, so abs_val leaves unsigned operands alone.
    assign mcand_ext  = {{(MAX_WIDTH-WIDTH){signed_op & multiplicand[WIDTH-1]}}, multiplicand};
    assign mplier_ext = {{(MAX_WIDTH-WIDTH){signed_op & multiplier[WIDTH-1]}}, multiplier};
    assign mcand_mag  = WIDTH'(abs_val(mcand_ext));
    assign mplier_mag = WIDTH'(abs_val(mplier_ext));
    assign neg_in     = signed_op & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);

    mult_step #(.WIDTH(WIDTH)) u_step (
        .acc_upper  (acc[2*WIDTH-1:WIDTH]),
        .mcand      (mcand),
        .mplier_bit (mplier[0]),
        .sum        (row_sum)
    );

    // {carry, acc_upper + addend, acc_lower} shifted right by one: the carry
    // becomes the new MSB and the consumed low bit drops out.
    assign acc_next = {row_sum, acc[WIDTH-1:1]};

    assign ready = (state != RUN);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would chain updates within a cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            counter  <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            neg_flag <= 1'b0;
            product  <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand    <= mcand_mag;
                        mplier   <= mplier_mag;
                        neg_flag <= neg_in;
                        acc      <= '0;
                        counter  <= '0;
                        state    <= RUN;
                    end else begin
                        state    <= IDLE;
                    end
                end
                RUN: begin
                    acc     <= acc_next;
                    mplier  <= mplier >> 1;
                    counter <= counter + CW'(1);
                    if (counter == LAST) begin
                        product <= neg_flag ? -acc_next : acc_next;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// ----------------------------------------------------------------------------
// tb_seq_multiplier
//   Self-checking bench for seq_multiplier. Four instances cover WIDTH=8
//   signed-capable, WIDTH=8 with SIGNED_EN=0, WIDTH=4 and WIDTH=13. Expected
//   products come from integer arithmetic on the operands' numeric values.
// ----------------------------------------------------------------------------
module tb_seq_multiplier;

    logic clock = 1'b0;
    logic reset;
    logic signed_mode;

    logic start8, startu, start4, start13;
    logic [7:0]  a8, b8, au, bu;
    logic [3:0]  a4, b4;
    logic [12:0] a13, b13;

    logic        ready8, readyu, ready4, ready13;
    logic        done8, doneu, done4, done13;
    logic [15:0] prod8, produ;
    logic [7:0]  prod4;
    logic [25:0] prod13;

    int n_checks = 0;
    int n_errors = 0;
    int cur_sel  = 0;

    logic        done_sel;
    logic        ready_sel;
    logic [25:0] prod_sel;

    always #5 clock = ~clock;

    seq_multiplier #(.WIDTH(8), .SIGNED_EN(1)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .signedMode(signed_mode),
        .multiplicand(a8), .multiplier(b8), .ready(ready8), .done(done8), .product(prod8));

    seq_multiplier #(.WIDTH(8), .SIGNED_EN(0)) dutu (
        .clock(clock), .reset(reset), .start(startu), .signedMode(signed_mode),
        .multiplicand(au), .multiplier(bu), .ready(readyu), .done(doneu), .product(produ));

    seq_multiplier #(.WIDTH(4), .SIGNED_EN(1)) dut4 (
        .clock(clock), .reset(reset), .start(start4), .signedMode(signed_mode),
        .multiplicand(a4), .multiplier(b4), .ready(ready4), .done(done4), .product(prod4));

    seq_multiplier #(.WIDTH(13), .SIGNED_EN(1)) dut13 (
        .clock(clock), .reset(reset), .start(start13), .signedMode(signed_mode),
        .multiplicand(a13), .multiplier(b13), .ready(ready13), .done(done13), .product(prod13));

    always_comb begin
        done_sel  = 1'b0;
        ready_sel = 1'b0;
        prod_sel  = '0;
        case (cur_sel)
            0: begin done_sel = done8;  ready_sel = ready8;  prod_sel = {10'd0, prod8}; end
            1: begin done_sel = doneu;  ready_sel = readyu;  prod_sel = {10'd0, produ}; end
            2: begin done_sel = done4;  ready_sel = ready4;  prod_sel = {18'd0, prod4}; end
            default: begin done_sel = done13; ready_sel = ready13; prod_sel = prod13; end
        endcase
    end

    function automatic int width_of(input int sel);
        case (sel)
            2:       return 4;
            3:       return 13;
            default: return 8;
        endcase
    endfunction

    // Reference: interpret operands as integers, multiply, wrap to 2*w bits.
    function automatic logic [63:0] ref_mult(input int w, input bit sgn,
                                             input logic [63:0] a, input logic [63:0] b);
        longint sa, sb, p;
        logic [63:0] mask;
        sa = longint'(a);
        sb = longint'(b);
        if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
        if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
        p    = sa * sb;
        mask = (64'd1 << (2 * w)) - 64'd1;
        return 64'(p) & mask;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0: start8 = v;
            1: startu = v;
            2: start4 = v;
            default: start13 = v;
        endcase
    endtask

    task automatic set_ops(input int sel, input logic [12:0] a, input logic [12:0] b);
        case (sel)
            0: begin a8 = a[7:0]; b8 = b[7:0]; end
            1: begin au = a[7:0]; bu = b[7:0]; end
            2: begin a4 = a[3:0]; b4 = b[3:0]; end
            default: begin a13 = a; b13 = b; end
        endcase
    endtask

    task automatic launch(input int sel, input logic [12:0] a, input logic [12:0] b, input logic sm);
        @(negedge clock);
        cur_sel     = sel;
        signed_mode = sm;
        set_ops(sel, a, b);
        set_start(sel, 1'b1);
    endtask

    // Counts falling edges after the launch until done is seen; 0 means timeout.
    task automatic wait_done(output int lat, output logic [25:0] prod);
        lat  = 0;
        prod = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (k == 1) set_start(cur_sel, 1'b0);
            if (done_sel) begin
                lat  = k;
                prod = prod_sel;
                break;
            end
        end
    endtask

    task automatic op_check(input int sel, input logic [12:0] a, input logic [12:0] b,
                            input logic sm, input logic [63:0] exp, input string tag);
        int          lat;
        logic [25:0] p;
        launch(sel, a, b, sm);
        wait_done(lat, p);
        check({tag, "_lat"}, 64'(lat), 64'(width_of(sel) + 1));
        check({tag, "_prod"}, 64'(p), exp);
        @(negedge clock);
        check({tag, "_pulse"}, 64'(done_sel), 64'd0);
    endtask

    initial begin
        int          lat;
        int          w;
        int          extra_done;
        logic [25:0] p;
        logic [12:0] ra, rb, mask;
        logic        rs;

        signed_mode = 1'b0;
        start8 = 1'b0; startu = 1'b0; start4 = 1'b0; start13 = 1'b0;
        a8 = '0; b8 = '0; au = '0; bu = '0; a4 = '0; b4 = '0; a13 = '0; b13 = '0;

        // Reset held two cycles with start asserted: reset wins.
        reset  = 1'b1;
        start8 = 1'b1;
        a8 = 8'd9; b8 = 8'd9;
        repeat (2) @(negedge clock);
        check("rst_prod",  64'(prod8),  64'd0);
        check("rst_done",  64'(done8),  64'd0);
        check("rst_ready", 64'(ready8), 64'd1);
        start8 = 1'b0;
        reset  = 1'b0;

        // Directed products
        op_check(0, 13'd200,  13'd255,  1'b0, 64'hC738, "u200x255");
        op_check(0, 13'h0FD,  13'h005,  1'b1, 64'hFFF1, "s_m3x5");
        op_check(0, 13'h080,  13'h080,  1'b1, 64'h4000, "s_m128xm128");
        op_check(0, 13'h080,  13'h07F,  1'b1, 64'hC080, "s_m128x127");
        op_check(0, 13'h0FD,  13'h005,  1'b0, 64'h04F1, "u_253x5");
        op_check(1, 13'h0FF,  13'h0FF,  1'b1, 64'hFE01, "nosign_ffxff");

        // Start while busy is ignored; start in the DONE cycle is accepted.
        launch(0, 13'd200, 13'd255, 1'b0);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (k == 1) start8 = 1'b0;
            if (k == 3) begin start8 = 1'b1; a8 = 8'd7; b8 = 8'd7; signed_mode = 1'b1; end
            if (k == 4) start8 = 1'b0;
            if (done8) begin lat = k; break; end
        end
        check("busy_lat",  64'(lat),   64'd9);
        check("busy_prod", 64'(prod8), 64'hC738);
        a8 = 8'd7; b8 = 8'd9; signed_mode = 1'b0; start8 = 1'b1;
        @(negedge clock);
        start8 = 1'b0;
        check("b2b_done_low", 64'(done8),  64'd0);
        check("b2b_busy",     64'(ready8), 64'd0);
        check("b2b_hold",     64'(prod8),  64'hC738);
        wait_done(lat, p);
        check("b2b_lat",  64'(lat + 1), 64'd9);
        check("b2b_prod", 64'(p),       64'h003F);
        @(negedge clock);
        check("b2b_pulse", 64'(done8),  64'd0);
        check("b2b_idle",  64'(ready8), 64'd1);

        // Reset in the middle of an operation aborts it.
        launch(0, 13'd200, 13'd255, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            if (k == 1) start8 = 1'b0;
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_prod",  64'(prod8),  64'd0);
        check("abort_done",  64'(done8),  64'd0);
        check("abort_ready", 64'(ready8), 64'd1);
        extra_done = 0;
        repeat (12) begin
            @(negedge clock);
            if (done8) extra_done++;
        end
        check("abort_no_done", 64'(extra_done), 64'd0);
        op_check(0, 13'd15, 13'd15, 1'b0, 64'h00E1, "after_abort_15x15");

        // Random sweep over all instances, both modes, biased toward extremes.
        for (int sel = 0; sel < 4; sel++) begin
            w    = width_of(sel);
            mask = 13'((32'd1 << w) - 32'd1);
            for (int n = 0; n < 30; n++) begin
                ra = 13'($urandom) & mask;
                rb = 13'($urandom) & mask;
                rs = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) ra = 13'(32'd1 << (w - 1));
                if ($urandom_range(0, 5) == 0) rb = mask;
                op_check(sel, ra, rb, rs,
                         ref_mult(w, rs && (sel != 1), 64'(ra), 64'(rb)),
                         $sformatf("rand_w%0d_s%0d_%0h_%0h", w, rs, ra, rb));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
